// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - UART byte input, instruction-memory write port and load status
// master drives the byte stream and start; slave is the loader.
interface uart_prog_loader_if #(
  parameter int ADDR_W = 14
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [15:0]       words_loaded;

  modport master (
    output start, rx_valid, rx_data,
    input  wr_en, wr_addr, wr_data, cpu_hold, done, err, words_loaded
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output wr_en, wr_addr, wr_data, cpu_hold, done, err, words_loaded
  );
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - packs a length-prefixed UART byte stream into instruction-memory words
// Holds the CPU in reset while a load is in progress; aborts on an oversize length or an inter-byte timeout.
module uart_prog_loader #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 5_000_000
) (
  input  logic               clock,
  input  logic               reset,
  uart_prog_loader_if.slave  bus
);
  localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [16:0]   MAX_LEN  = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
  } state_t;

  state_t            r_state;
  logic [15:0]       r_len;
  logic [1:0]        r_idx;
  logic [23:0]       r_word;
  logic [TW-1:0]     r_tmo;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [15:0]       r_words;

  logic        w_busy;
  logic        w_tmo_hit;
  logic        w_last_write;
  logic [15:0] w_full_len;

  assign w_busy       = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) || (r_state == S_DATA);
  assign w_tmo_hit    = !bus.rx_valid && (r_tmo == TMO_LAST);
  assign w_last_write = r_wr_en && ((r_words + 16'd1) == r_len);
  assign w_full_len   = {bus.rx_data, r_len[7:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_tmo      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_words    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_busy) r_tmo <= bus.rx_valid ? '0 : r_tmo + TW'(1);
      // The address saturates so a full-capacity load leaves it on the last word.
      if (r_wr_en) begin
        r_words <= r_words + 16'd1;
        if (r_wr_addr != '1) r_wr_addr <= r_wr_addr + 1'b1;
      end

      unique case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (bus.start) begin
            r_state    <= S_LEN_LO;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= '0;
            r_wr_addr  <= '0;
            r_idx      <= '0;
            r_tmo      <= '0;
            r_cpu_hold <= 1'b1;
          end
        end
        S_LEN_LO: begin
          if (bus.rx_valid) begin
            r_len[7:0] <= bus.rx_data;
            r_state    <= S_LEN_HI;
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
        end
        S_LEN_HI: begin
          if (bus.rx_valid) begin
            r_len[15:8] <= bus.rx_data;
            if (w_full_len == 16'd0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if ({1'b0, w_full_len} > MAX_LEN) begin
              r_state    <= S_ERR;
              r_err      <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
        end
        S_DATA: begin
          if (w_last_write) begin
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else if (bus.rx_valid) begin
            r_idx <= r_idx + 2'd1;
            unique case (r_idx)
              2'd0:    r_word[7:0]   <= bus.rx_data;
              2'd1:    r_word[15:8]  <= bus.rx_data;
              2'd2:    r_word[23:16] <= bus.rx_data;
              default: begin
                r_wr_en   <= 1'b1;
                r_wr_data <= {bus.rx_data, r_word};
              end
            endcase
          end else if (w_tmo_hit) begin
            r_state    <= S_ERR;
            r_err      <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_en        = r_wr_en;
  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_data      = r_wr_data;
  assign bus.cpu_hold     = r_cpu_hold;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.words_loaded = r_words;
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - bench for uart_prog_loader
// Vector table, directed corner sequences and randomized frames against a frame-level model.
module tb_uart_prog_loader;
  localparam int AW  = 4;
  localparam int TMO = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_prog_loader_if #(.ADDR_W(AW)) bus ();

  uart_prog_loader #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] wa_q[$];
  logic [31:0]   wd_q[$];
  logic [AW-1:0] ea_q[$];
  logic [31:0]   ed_q[$];

  always @(negedge clock) begin
    if (bus.wr_en) begin
      wa_q.push_back(bus.wr_addr);
      wd_q.push_back(bus.wr_data);
    end
  end

  typedef struct {
    int          n;
    logic [95:0] b;
    bit          exp_done;
    bit          exp_err;
    int          exp_words;
    int          exp_nwr;
    logic [3:0]  exp_last_addr;
    logic [31:0] exp_last_data;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    cyc();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!(bus.done || bus.err) && n < 200) begin
      cyc();
      n++;
    end
    chk({name, " finished"}, 32'(bus.done | bus.err), 32'd1);
  endtask

  task automatic clear_q();
    wa_q.delete(); wd_q.delete();
    ea_q.delete(); ed_q.delete();
  endtask

  task automatic cmp_writes(input string name);
    chk({name, " nwr"}, wa_q.size(), ea_q.size());
    for (int i = 0; i < ea_q.size() && i < wa_q.size(); i++) begin
      chk($sformatf("%s addr%0d", name, i), 32'(wa_q[i]), 32'(ea_q[i]));
      chk($sformatf("%s data%0d", name, i), wd_q[i], ed_q[i]);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic [7:0]  st[$];
    logic [31:0] wq[$];
    int len, full, t, nw, gap;
    bit  e_err, e_done;

    vt[0] = '{10, 96'h02_00_78_56_34_12_EF_BE_AD_DE_00_00, 1'b1, 1'b0, 2, 2, 4'd1, 32'hDEADBEEF};
    vt[1] = '{2,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 1'b1, 1'b0, 0, 0, 4'd0, 32'h0};
    vt[2] = '{4,  96'h01_00_AA_BB_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 0, 0, 4'd0, 32'h0};
    vt[3] = '{2,  96'h00_01_00_00_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 0, 0, 4'd0, 32'h0};
    vt[4] = '{2,  96'h11_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 0, 0, 4'd0, 32'h0};
    vt[5] = '{6,  96'h01_00_11_22_33_44_00_00_00_00_00_00, 1'b1, 1'b0, 1, 1, 4'd0, 32'h44332211};
    vt[6] = '{8,  96'h02_00_01_02_03_04_05_06_00_00_00_00, 1'b0, 1'b1, 1, 1, 4'd0, 32'h04030201};
    vt[7] = '{1,  96'h01_00_00_00_00_00_00_00_00_00_00_00, 1'b0, 1'b1, 0, 0, 4'd0, 32'h0};

    bus.start = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) cyc();
    chk("rst wr_en", 32'(bus.wr_en), 0);
    chk("rst cpu_hold", 32'(bus.cpu_hold), 0);
    reset = 1'b1;
    cyc();
    chk("rst done", 32'(bus.done), 0);
    chk("rst err", 32'(bus.err), 0);
    chk("rst wr_addr", 32'(bus.wr_addr), 0);
    chk("rst wr_data", bus.wr_data, 0);
    chk("rst words", 32'(bus.words_loaded), 0);

    // Reset in the middle of a load
    clear_q();
    pulse_start();
    send(8'h01); send(8'h00); send(8'hAA);
    chk("midload cpu_hold", 32'(bus.cpu_hold), 1);
    reset = 1'b0;
    #1;
    chk("async rst cpu_hold", 32'(bus.cpu_hold), 0);
    cyc();
    reset = 1'b1;
    cyc();
    send_word(32'h11223344);
    cyc();
    chk("post rst no writes", wa_q.size(), 0);
    chk("post rst cpu_hold", 32'(bus.cpu_hold), 0);
    chk("post rst done", 32'(bus.done), 0);
    chk("post rst words", 32'(bus.words_loaded), 0);

    for (int v = 0; v < 8; v++) begin
      clear_q();
      pulse_start();
      for (int i = 0; i < vt[v].n; i++) send(vt[v].b[95-8*i -: 8]);
      wait_end($sformatf("vec%0d", v));
      chk($sformatf("vec%0d done", v), 32'(bus.done), 32'(vt[v].exp_done));
      chk($sformatf("vec%0d err", v), 32'(bus.err), 32'(vt[v].exp_err));
      chk($sformatf("vec%0d cpu_hold", v), 32'(bus.cpu_hold), 0);
      chk($sformatf("vec%0d words", v), 32'(bus.words_loaded), 32'(vt[v].exp_words));
      chk($sformatf("vec%0d nwr", v), wa_q.size(), vt[v].exp_nwr);
      if (vt[v].exp_nwr > 0 && wa_q.size() > 0) begin
        chk($sformatf("vec%0d last addr", v), 32'(wa_q[$]), 32'(vt[v].exp_last_addr));
        chk($sformatf("vec%0d last data", v), wd_q[$], vt[v].exp_last_data);
      end
    end

    // Write latency: wr_en one cycle after byte 3, DONE as it falls
    clear_q();
    pulse_start();
    send(8'h01); send(8'h00); send(8'h11); send(8'h22); send(8'h33);
    chk("lat wr_en early", 32'(bus.wr_en), 0);
    send(8'h44);
    chk("lat wr_en", 32'(bus.wr_en), 1);
    chk("lat wr_addr", 32'(bus.wr_addr), 0);
    chk("lat wr_data", bus.wr_data, 32'h44332211);
    chk("lat hold", 32'(bus.cpu_hold), 1);
    chk("lat done early", 32'(bus.done), 0);
    cyc();
    chk("lat wr_en fall", 32'(bus.wr_en), 0);
    chk("lat done", 32'(bus.done), 1);
    chk("lat hold fall", 32'(bus.cpu_hold), 0);
    chk("lat words", 32'(bus.words_loaded), 1);

    // Full-capacity load back-to-back
    clear_q();
    pulse_start();
    send(8'h10); send(8'h00);
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      ea_q.push_back(AW'(i));
      ed_q.push_back(w);
      send_word(w);
    end
    wait_end("full");
    cmp_writes("full");
    chk("full done", 32'(bus.done), 1);
    chk("full err", 32'(bus.err), 0);
    chk("full words", 32'(bus.words_loaded), 16);

    // start mid-DATA ignored, rx in DONE ignored, restart clears status
    clear_q();
    pulse_start();
    send(8'h02); send(8'h00);
    send_word(32'hCAFEF00D);
    pulse_start();
    send_word(32'h0BADBEEF);
    wait_end("ign");
    ea_q = '{AW'(0), AW'(1)};
    ed_q = '{32'hCAFEF00D, 32'h0BADBEEF};
    cmp_writes("ign");
    chk("ign words", 32'(bus.words_loaded), 2);
    send_word(32'h01020304);
    cyc();
    chk("done rx nwr", wa_q.size(), 2);
    chk("done rx done", 32'(bus.done), 1);
    chk("done rx words", 32'(bus.words_loaded), 2);
    pulse_start();
    chk("restart done", 32'(bus.done), 0);
    chk("restart words", 32'(bus.words_loaded), 0);
    chk("restart addr", 32'(bus.wr_addr), 0);
    chk("restart hold", 32'(bus.cpu_hold), 1);
    clear_q();
    send(8'h01); send(8'h00);
    send_word(32'h55AA55AA);
    wait_end("restart");
    ea_q = '{AW'(0)};
    ed_q = '{32'h55AA55AA};
    cmp_writes("restart");

    // Timeout boundary: TMO-1 idle cycles survive, TMO aborts
    clear_q();
    pulse_start();
    repeat (TMO - 1) cyc();
    send(8'h01);
    chk("tmo edge err", 32'(bus.err), 0);
    chk("tmo edge hold", 32'(bus.cpu_hold), 1);
    repeat (TMO - 1) cyc();
    chk("tmo last err", 32'(bus.err), 0);
    cyc();
    chk("tmo fire err", 32'(bus.err), 1);
    chk("tmo fire hold", 32'(bus.cpu_hold), 0);

    // Randomized frames against a frame-level model
    for (int it = 0; it < 40; it++) begin
      clear_q();
      st.delete(); wq.delete();
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(17, 40) : $urandom_range(0, 16);
      st.push_back(8'(len)); st.push_back(8'(len >> 8));
      if (len >= 1 && len <= 16) begin
        for (int i = 0; i < len; i++) begin
          w = $urandom;
          wq.push_back(w);
          for (int k = 0; k < 4; k++) st.push_back(w[8*k +: 8]);
        end
      end
      full = st.size();
      t = ($urandom_range(0, 3) == 0) ? $urandom_range(0, full - 1) : full;
      if (t < 2)                  begin e_err = 1; nw = 0; end
      else if (len == 0)          begin e_err = 0; nw = 0; end
      else if (len > 16)          begin e_err = 1; nw = 0; end
      else                        begin e_err = (t < full); nw = (t - 2) / 4; end
      e_done = !e_err;
      for (int i = 0; i < nw; i++) begin
        ea_q.push_back(AW'(i));
        ed_q.push_back(wq[i]);
      end
      pulse_start();
      for (int i = 0; i < t; i++) begin
        gap = $urandom_range(0, 1) ? 0 : $urandom_range(1, TMO - 1);
        repeat (gap) cyc();
        send(st[i]);
      end
      wait_end($sformatf("rnd%0d", it));
      cmp_writes($sformatf("rnd%0d", it));
      chk($sformatf("rnd%0d done", it), 32'(bus.done), 32'(e_done));
      chk($sformatf("rnd%0d err", it), 32'(bus.err), 32'(e_err));
      chk($sformatf("rnd%0d words", it), 32'(bus.words_loaded), 32'(nw));
      chk($sformatf("rnd%0d hold", it), 32'(bus.cpu_hold), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
